fetch_unit: RTL

- PC register and instruction-fetch sequencer for the single-cycle RV32I core; sits directly upstream of the ALU/execute stage.
- Issues instruction-memory requests over a valid/ready handshake and holds the returned instruction and its PC stable for execute.
- On `commit`, selects the next PC from the execute results (branch decision, jump target, JAL offset) and starts the next fetch.

---
 rtl/rv_pkg.sv | 22 ++
 rtl/next_pc_sel.sv | 35 +++
 rtl/fetch_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: base opcodes and the fetch sequencer states.
// Imported by next_pc_sel and fetch_unit.
package rv_pkg;

  localparam logic [6:0] LUI_OP   = 7'b0110111;
  localparam logic [6:0] AUIPC_OP = 7'b0010111;
  localparam logic [6:0] JAL_OP   = 7'b1101111;
  localparam logic [6:0] JALR_OP  = 7'b1100111;
  localparam logic [6:0] BR_OP    = 7'b1100011;
  localparam logic [6:0] LOAD_OP  = 7'b0000011;
  localparam logic [6:0] STORE_OP = 7'b0100011;
  localparam logic [6:0] OPIMM_OP = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux: JALR > JAL > taken branch > pc+4.
// Ports: pc_i, opcode_i, branch_taken_i, jump_target_i, jal_offset_i -> next_pc_o.
module next_pc_sel
  import rv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic [6:0]       opcode_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic [WIDTH-1:0] jal_offset_i,
  output logic [WIDTH-1:0] next_pc_o
);

  logic is_jalr;
  logic is_jal;
  logic is_br_tk;

  assign is_jalr  = (opcode_i == JALR_OP);
  assign is_jal   = (opcode_i == JAL_OP);
  assign is_br_tk = (opcode_i == BR_OP) && branch_taken_i;

  // Opcodes are distinct, so the three selects are mutually exclusive.
  always_comb begin
    next_pc_o = pc_i + WIDTH'(4);
    unique case (1'b1)
      is_jalr:  next_pc_o = jump_target_i;
      is_jal:   next_pc_o = pc_i + jal_offset_i;
      is_br_tk: next_pc_o = jump_target_i;
      default:  next_pc_o = pc_i + WIDTH'(4);
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register + fetch FSM (FETCH/WAIT/EXEC[/FAULT]) feeding execute.
// Ports: imem req/rsp handshake, instr/pc/instr_valid out, commit + execute results in.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned next_pc raises sticky fetch_fault.
module fetch_unit
  import rv_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [WIDTH-1:0] pc,
  input  logic             commit,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] jal_offset,
  output logic             fetch_fault
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] next_pc;
  logic [31:0]      instr_q, instr_d;
  logic             iv_q, iv_d;
  logic             fault_q, fault_d;

  next_pc_sel #(.WIDTH(WIDTH)) u_npc (
    .pc_i           (pc_q),
    .opcode_i       (opcode),
    .branch_taken_i (branch_taken),
    .jump_target_i  (jump_target),
    .jal_offset_i   (jal_offset),
    .next_pc_o      (next_pc)
  );

`ifndef FETCH_MISALIGN_TRAP_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    iv_d    = iv_q;
    fault_d = fault_q;
    unique case (state_q)
      FETCH: begin
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          iv_d    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (commit) begin
          iv_d    = 1'b0;
          state_d = FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
          pc_d = next_pc;
          if (next_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end
`else
          pc_d = next_pc & ALIGN_MASK;
`endif
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      iv_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      iv_q    <= iv_d;
      fault_q <= fault_d;
    end
  end

  // Gate with rst_n so the request drops the instant reset asserts.
  assign imem_req_valid = rst_n && (state_q == FETCH);
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = iv_q;
  assign fetch_fault    = fault_q;

endmodule
